// File: rtl/clk_rate_pkg.sv
// clk_rate_pkg
// Shared types and helpers for the clock-rate scheduler.
//   sched_state_t : scheduler FSM states
//   DEF_WIDTH     : default width of the divider terminal count
//   rate_of()     : MAX_VAL for a given ladder level, floored at a minimum
package clk_rate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TOP  = 2'd2
  } sched_state_t;

  localparam int DEF_WIDTH = 33;

  // Geometric ladder: each level halves the base, never dropping below min_val.
  function automatic logic [DEF_WIDTH-1:0] rate_of(
    input int unsigned          level,
    input logic [DEF_WIDTH-1:0] base,
    input logic [DEF_WIDTH-1:0] min_val
  );
    logic [DEF_WIDTH-1:0] shifted;
    shifted = base >> level;
    return (shifted < min_val) ? min_val : shifted;
  endfunction

endpackage

// File: rtl/rate_tick_counter.sv
// rate_tick_counter
// Counts divider ticks spent at the current level. Saturates at all-ones
// instead of wrapping, so a long stay at the top level cannot alias back
// to a terminal count.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous clear (priority over inc)
//   inc      : count one tick
//   terminal : count has reached TICKS_PER_LEVEL-1
module rate_tick_counter #(
  parameter int TICKS_PER_LEVEL = 4,
  parameter int CW              = $clog2(TICKS_PER_LEVEL) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  logic [CW-1:0] count_r;

  // Saturating tick counter with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (inc && (count_r != {CW{1'b1}})) begin
      count_r <= count_r + CW'(1'b1);
    end
  end

  assign terminal = (count_r == CW'(TICKS_PER_LEVEL - 1));

endmodule

// File: rtl/clk_rate_sched.sv
// clk_rate_sched
// Drives the variable clock divider's MAX_VAL through a halving ladder of
// rates. A level advance happens only on a cycle where TICK (the divider's
// STAB_RATE_OUT) is high, so the divider never sees MAX_VAL change mid-period.
//   DIV_CLK  : system clock, shared with the divider
//   RST_N    : asynchronous active-low reset
//   START    : pulse, (re)start the ramp at level 0
//   STOP     : pulse, abort to idle (highest priority)
//   BOOST    : pulse, request one early advance at the next TICK
//   TICK     : pulse from the divider marking a period boundary
//   MAX_VAL  : divider terminal count
//   DIV_EN   : divider enable (same as RUNNING)
//   LEVEL    : current ladder level
//   RUNNING  : ramp active (RUN or TOP)
//   LEVEL_UP : one-cycle pulse after each level advance
//   AT_MAX   : ramp sitting at the last level
module clk_rate_sched
  import clk_rate_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter int               NUM_LEVELS      = 8,
  parameter int               TICKS_PER_LEVEL = 4,
  parameter logic [WIDTH-1:0] BASE_VAL        = 33'h0_0002_0000,
  parameter logic [WIDTH-1:0] MIN_VAL         = 33'h0_0000_0400,
  localparam int              LW              = $clog2(NUM_LEVELS)
) (
  input  logic             DIV_CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             BOOST,
  input  logic             TICK,
  output logic [WIDTH-1:0] MAX_VAL,
  output logic             DIV_EN,
  output logic [LW-1:0]    LEVEL,
  output logic             RUNNING,
  output logic             LEVEL_UP,
  output logic             AT_MAX
);

  sched_state_t     state_r;
  sched_state_t     state_nxt_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic [LW-1:0]    level_inc_s;
  logic [WIDTH-1:0] max_val_r;
  logic [WIDTH-1:0] max_val_nxt_s;
  logic             boost_pend_r;
  logic             boost_pend_nxt_s;
  logic             level_up_r;
  logic             level_up_nxt_s;
  logic             running_r;
  logic             at_max_r;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             cnt_term_s;

  assign level_inc_s = level_r + LW'(1'b1);

  rate_tick_counter #(
    .TICKS_PER_LEVEL(TICKS_PER_LEVEL)
  ) u_tick_cnt (
    .clk      (DIV_CLK),
    .rst_n    (RST_N),
    .clr      (cnt_clr_s),
    .inc      (cnt_inc_s),
    .terminal (cnt_term_s)
  );

  // Next-state, ladder register and counter control; STOP > START > TICK/BOOST.
  always_comb begin
    state_nxt_s      = state_r;
    level_nxt_s      = level_r;
    max_val_nxt_s    = max_val_r;
    boost_pend_nxt_s = boost_pend_r;
    level_up_nxt_s   = 1'b0;
    cnt_clr_s        = 1'b0;
    cnt_inc_s        = 1'b0;

    if (STOP) begin
      state_nxt_s      = IDLE;
      level_nxt_s      = {LW{1'b0}};
      max_val_nxt_s    = BASE_VAL;
      boost_pend_nxt_s = 1'b0;
      cnt_clr_s        = 1'b1;
    end else if (START) begin
      // Restart never pulses LEVEL_UP, and a BOOST on this edge is dropped.
      state_nxt_s      = RUN;
      level_nxt_s      = {LW{1'b0}};
      max_val_nxt_s    = BASE_VAL;
      boost_pend_nxt_s = 1'b0;
      cnt_clr_s        = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        RUN: begin
          if (TICK && (cnt_term_s || boost_pend_r)) begin
            // Auto-advance and a pending boost on the same tick merge into one level.
            level_nxt_s      = level_inc_s;
            max_val_nxt_s    = rate_of(32'(level_inc_s), BASE_VAL, MIN_VAL);
            boost_pend_nxt_s = 1'b0;
            level_up_nxt_s   = 1'b1;
            cnt_clr_s        = 1'b1;
            state_nxt_s      = (level_inc_s == LW'(NUM_LEVELS - 1)) ? TOP : RUN;
          end else begin
            cnt_inc_s        = TICK;
            boost_pend_nxt_s = boost_pend_r | BOOST;
          end
        end
        TOP: begin
          cnt_inc_s = TICK;
        end
        default: begin
          state_nxt_s      = IDLE;
          level_nxt_s      = {LW{1'b0}};
          max_val_nxt_s    = BASE_VAL;
          boost_pend_nxt_s = 1'b0;
          cnt_clr_s        = 1'b1;
        end
      endcase
    end
  end

  // State, ladder and registered status outputs.
  always_ff @(posedge DIV_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      level_r      <= {LW{1'b0}};
      max_val_r    <= BASE_VAL;
      boost_pend_r <= 1'b0;
      level_up_r   <= 1'b0;
      running_r    <= 1'b0;
      at_max_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      level_r      <= level_nxt_s;
      max_val_r    <= max_val_nxt_s;
      boost_pend_r <= boost_pend_nxt_s;
      level_up_r   <= level_up_nxt_s;
      running_r    <= (state_nxt_s != IDLE);
      at_max_r     <= (state_nxt_s == TOP);
    end
  end

  assign MAX_VAL  = max_val_r;
  assign LEVEL    = level_r;
  assign RUNNING  = running_r;
  assign DIV_EN   = running_r;
  assign LEVEL_UP = level_up_r;
  assign AT_MAX   = at_max_r;

endmodule

// File: tb/tb_clk_rate_sched.sv
// tb_clk_rate_sched
// Directed bench for clk_rate_sched. Every stimulus that should cause a level
// advance pushes the expected level, MAX_VAL and clock edge into a queue; a
// separate monitor pops and compares on every LEVEL_UP pulse. Static state is
// checked directly against hand-computed constants.
module tb_clk_rate_sched;

  logic        div_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        boost   = 1'b0;
  logic        tick    = 1'b0;
  logic [32:0] max_val;
  logic        div_en;
  logic [2:0]  level;
  logic        running;
  logic        level_up;
  logic        at_max;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  lvl;
    logic [32:0] val;
    int          edge_n;
  } exp_t;

  exp_t exp_q[$];

  // Hand-computed ladder: 0x20000 >> k, floor 0x400.
  logic [32:0] rate_tbl [8] = '{33'h20000, 33'h10000, 33'h08000, 33'h04000,
                                33'h02000, 33'h01000, 33'h00800, 33'h00400};

  clk_rate_sched dut (
    .DIV_CLK  (div_clk),
    .RST_N    (rst_n),
    .START    (start),
    .STOP     (stop),
    .BOOST    (boost),
    .TICK     (tick),
    .MAX_VAL  (max_val),
    .DIV_EN   (div_en),
    .LEVEL    (level),
    .RUNNING  (running),
    .LEVEL_UP (level_up),
    .AT_MAX   (at_max)
  );

  always #5 div_clk = ~div_clk;

  always @(posedge div_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string tag, input int lvl, input logic [32:0] val,
                           input logic run, input logic atm);
    chk({tag, "_level"},   64'(level),   64'(lvl));
    chk({tag, "_max_val"}, 64'(max_val), 64'(val));
    chk({tag, "_running"}, 64'(running), 64'(run));
    chk({tag, "_div_en"},  64'(div_en),  64'(run));
    chk({tag, "_at_max"},  64'(at_max),  64'(atm));
  endtask

  // Monitor: every LEVEL_UP pulse must match the oldest expectation.
  always @(negedge div_clk) begin
    if (rst_n && level_up) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_level_up: actual LEVEL_UP=1 LEVEL=%0d at edge %0d, required no pulse",
                 level, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lu_level",   64'(level),   64'(e.lvl));
        chk("lu_max_val", 64'(max_val), 64'(e.val));
        chk("lu_edge",    64'(cyc),     64'(e.edge_n));
      end
    end
  end

  task automatic step(input logic st, input logic sp, input logic bo, input logic ti);
    @(negedge div_clk);
    start = st;
    stop  = sp;
    boost = bo;
    tick  = ti;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // The edge right after the current negedge samples the driven inputs.
  task automatic expect_up(input int lvl);
    exp_t e;
    e.lvl    = 3'(lvl);
    e.val    = rate_tbl[lvl];
    e.edge_n = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic tick1(input logic adv, input int lvl);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    if (adv) expect_up(lvl);
    idle(9);
  endtask

  initial begin
    // Reset values
    #23;
    chk_state("reset", 0, 33'h20000, 1'b0, 1'b0);
    chk("reset_level_up", 64'(level_up), 64'(0));
    @(negedge div_clk);
    rst_n = 1'b1;

    // TICK and BOOST in IDLE do nothing
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk_state("idle_ignores", 0, 33'h20000, 1'b0, 1'b0);

    // START
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("start_no_level_up", 64'(level_up), 64'(0));
    chk_state("started", 0, 33'h20000, 1'b1, 1'b0);

    // Ramp to the top: every 4th tick advances
    for (int i = 1; i <= 28; i++) tick1(i % 4 == 0, i / 4);
    chk_state("top", 7, 33'h400, 1'b1, 1'b1);

    // TOP ignores TICK and BOOST
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      tick1(1'b0, 0);
    end
    chk_state("top_hold", 7, 33'h400, 1'b1, 1'b1);

    // Restart from TOP
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("restart_no_level_up", 64'(level_up), 64'(0));
    chk_state("restart", 0, 33'h20000, 1'b1, 1'b0);

    // Three BOOSTs without TICK coalesce and wait for a tick
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
    end
    chk_state("boost_no_tick", 0, 33'h20000, 1'b1, 1'b0);
    tick1(1'b1, 1);
    idle(20);
    chk_state("boost_adv", 1, 33'h10000, 1'b1, 1'b0);

    // Counter restarted by the boost advance
    for (int i = 1; i <= 4; i++) tick1(i == 4, 2);

    // BOOST on the auto-advance tick: one level, boost dropped, counter cleared
    for (int i = 0; i < 3; i++) tick1(1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    expect_up(3);
    idle(9);
    for (int i = 0; i < 3; i++) tick1(1'b0, 0);
    chk_state("level3", 3, 33'h4000, 1'b1, 1'b0);

    // STOP at level 3
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_state("stopped", 0, 33'h20000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick1(1'b0, 0);
    chk_state("stop_ignores_tick", 0, 33'h20000, 1'b0, 1'b0);

    // STOP beats START and BOOST
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk_state("stop_beats_start", 0, 33'h20000, 1'b0, 1'b0);

    // STOP beats an advancing TICK
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) tick1(1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk_state("stop_beats_tick", 0, 33'h20000, 1'b0, 1'b0);

    // START with BOOST: boost dropped, plain 4-tick advance
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    for (int i = 1; i <= 4; i++) tick1(i == 4, 1);
    chk_state("start_drops_boost", 1, 33'h10000, 1'b1, 1'b0);

    // Boost up to level 5
    for (int l = 2; l <= 5; l++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      tick1(1'b1, l);
    end
    chk_state("level5", 5, 33'h1000, 1'b1, 1'b0);

    // Asynchronous reset in mid-cycle
    @(posedge div_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_reset", 0, 33'h20000, 1'b0, 1'b0);
    chk("async_reset_level_up", 64'(level_up), 64'(0));
    @(negedge div_clk);
    rst_n = 1'b1;

    // START after reset restarts at level 0
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk_state("post_reset_start", 0, 33'h20000, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) tick1(i == 4, 1);
    chk_state("post_reset_ramp", 1, 33'h10000, 1'b1, 1'b0);

    idle(5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_rate_sched.md
Name: clk_rate_sched

Overview:
- Controller that configures the variable clock divider by driving its 33-bit MAX_VAL terminal-count input.
- Steps the divider through a geometric ladder of rates (each level halves MAX_VAL), advancing after a fixed number of divider ticks or on a BOOST request.
- Changes MAX_VAL only on a divider tick boundary, so the divider's internal count is never corrupted mid-period.
- Sits between game/UI control logic and the divider; the divider's STAB_RATE_OUT feeds back as TICK.

Parameters:
- WIDTH, 33, width of MAX_VAL.
- NUM_LEVELS, 8, number of rate levels (0..NUM_LEVELS-1).
- TICKS_PER_LEVEL, 4, divider ticks spent at each level before auto-advance (≥1).
- BASE_VAL, 33'h0_0002_0000, MAX_VAL at level 0.
- MIN_VAL, 33'h0_0000_0400, floor for MAX_VAL.

Ports:
- DIV_CLK  in  1  system clock; also clocks the divider.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  1-cycle pulse; begin ramp from level 0.
- STOP  in  1  1-cycle pulse; abort and return to idle.
- BOOST  in  1  1-cycle pulse; request an early advance by one level.
- TICK  in  1  1-cycle pulse from the divider's STAB_RATE_OUT.
- MAX_VAL  out  WIDTH  terminal count to the divider.
- DIV_EN  out  1  divider enable; equals RUNNING.
- LEVEL  out  $clog2(NUM_LEVELS)  current level.
- RUNNING  out  1  high in RUN or TOP.
- LEVEL_UP  out  1  1-cycle pulse on each level change.
- AT_MAX  out  1  high in TOP.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, MAX_VAL=BASE_VAL, LEVEL=0.
  - RUNNING, DIV_EN, LEVEL_UP, AT_MAX all 0.
  - Tick counter and boost_pend cleared.
- Rate table: rate(k) = max(BASE_VAL >> k, MIN_VAL), computed at WIDTH bits with no truncation.
- States and transitions:
  - IDLE: TICK ignored. On START go to RUN: LEVEL=0, MAX_VAL=BASE_VAL, counter=0.
  - RUN:
    - On each TICK the counter increments.
    - Advance occurs at the TICK edge when counter==TICKS_PER_LEVEL-1, or when boost_pend=1.
    - On advance: LEVEL+1, MAX_VAL=rate(LEVEL+1), counter=0, boost_pend=0, LEVEL_UP=1 on the next cycle.
    - If the new LEVEL==NUM_LEVELS-1, go to TOP.
  - TOP: AT_MAX=1. TICK only keeps the counter saturated. BOOST ignored. Stays until STOP.
- Any STOP in RUN or TOP returns to IDLE, and the same edge restores reset values of LEVEL, MAX_VAL, counter and boost_pend.
- BOOST handling:
  - BOOST in RUN sets boost_pend. The advance itself waits for the next TICK, so MAX_VAL is never updated between ticks.
  - Multiple BOOSTs before a TICK coalesce into one level.
  - Boost advance and auto-advance on the same TICK give one level, not two.
  - BOOST in IDLE is ignored.
- Latency: the MAX_VAL update is registered on the same DIV_CLK edge that samples TICK=1, so the divider's next period uses the new value. LEVEL_UP is high in the cycle after that edge.
- Simultaneous inputs:
  - STOP has priority over START and BOOST.
  - START while RUN/TOP restarts at level 0. The restart edge does not assert LEVEL_UP.
  - START+BOOST in the same cycle: START wins, boost dropped.
  - TICK+STOP: STOP wins.
- Counter width is $clog2(TICKS_PER_LEVEL)+1 and saturates; it never wraps.
- Reset mid-ramp: immediate async return to the reset values; no LEVEL_UP pulse is emitted.

Decomposition:
- Package clk_rate_pkg holds:
  - state enum sched_state_t {IDLE, RUN, TOP};
  - WIDTH default;
  - function rate_of(level, base, min) returning a WIDTH-bit value.
- One sub-module, rate_tick_counter: saturating TICK counter with clear and terminal flag.
- The FSM, boost_pend and the MAX_VAL register stay in clk_rate_sched.

Test Plan:
- Reset then START, drive TICK every 10 cycles, 4 ticks → LEVEL 0→1, MAX_VAL 0x20000→0x10000 on the 4th TICK edge, LEVEL_UP one cycle later.
- Run 28 TICKs → LEVEL reaches 7, MAX_VAL=0x400 (0x20000>>7), AT_MAX=1. Further TICK and BOOST change nothing.
- BOOST three times at level 0 with no TICK → MAX_VAL stays 0x20000. The next TICK gives LEVEL=1 exactly once.
- BOOST in the same cycle as the 4th auto-advance TICK → single advance to LEVEL=1, counter=0.
- STOP at LEVEL=3 (MAX_VAL=0x4000) → next edge IDLE, MAX_VAL=0x20000, RUNNING=0. Subsequent TICKs are ignored.
- Assert RST_N=0 mid-cycle at LEVEL=5 → outputs take reset values immediately, before the next DIV_CLK edge. START after release restarts at level 0.
